ctrl_pipeline: RTL
==================

Name: ctrl_pipeline

Overview:
- Parametrised successor to the single-stage control decoder for the 64-bit ARM pipelined CPU.
- Decodes the ID-stage opcode and carries the resulting control bundle through registered EX, MEM and WB stages.
- Detects load-use hazards, generates stall and flush controls, and keeps saturating stall/flush event counters.
- Sits between IF/ID and the datapath stage registers. It replaces ad-hoc bubble_ctrl generation.

Parameters:
- REG_AW, 5, register address width.
- ZERO_REG, 31, register index whose writes are suppressed.
- LINK_REG, 30, destination forced for BL.
- DELAY_SLOT, 0: 1 = the instruction after a taken branch executes; 0 = it is flushed.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset: one clock; reset is synchronous and active-high
- id_valid  in  1  IF/ID holds a real instruction
- id_opcode  in  11  instruction[31:21]
- id_rn  in  REG_AW  Rn field
- id_rm  in  REG_AW  Rm field
- id_rd  in  REG_AW  Rd/Rt field
- br_taken  in  1  branch resolved taken in EX this cycle
- stall  out  1  hold PC and IF/ID
- flush_ifid  out  1  squash IF/ID contents
- ex_alu_src  out  1  EX-stage control: ALU operand select
- ex_alu_op  out  2  EX-stage control: 00 pass-B, 01 add, 10 sub
- ex_set_flags  out  1  EX-stage control: update flags
- ex_sel_se  out  5  EX-stage control, {I,D,B,CB,cbz}: sign-extend select
- ex_linked_br  out  1  EX-stage control: link branch
- ex_reg_br  out  1  EX-stage control: register branch
- mem_branch  out  1  MEM-stage control
- mem_read  out  1  MEM-stage control
- mem_write  out  1  MEM-stage control
- wb_reg_write  out  1  WB-stage control
- wb_mem_to_reg  out  1  WB-stage control
- wb_rd  out  REG_AW  WB-stage control: destination register
- stall_cnt  out  CNT_W  stall cycles counted
- flush_cnt  out  CNT_W  flushes counted

Behaviour:
- Reset: all stage registers load the bubble (all zeros). Every output is 0, including both counters and wb_rd.
- Decode (combinational, ID stage):
  - ADDI 1001000100x: alu_src=1, op=01, reg_write=1, I.
  - ADDS 10101011000: op=01, reg_write=1, set_flags=1.
  - SUBS 11101011000: op=10, reg_write=1, set_flags=1.
  - B 000101xxxxx: branch=1, B.
  - BL 100101xxxxx: branch=1, B, linked_br=1, reg_write=1, rd=LINK_REG.
  - BR 11010110000: branch=1, B, reg_br=1.
  - CBZ 10110100xxx: branch=1, CB, cbz.
  - B.LT 01010100xxx: alu_src=1, op=10, branch=1, CB.
  - LDUR 11111000010: alu_src=1, op=01, mem_read=1, mem_to_reg=1, reg_write=1, D.
  - STUR 11111000000: alu_src=1, op=01, mem_write=1, D.
  - Any other opcode, or id_valid=0, decodes to a bubble.
  - reg_write is forced to 0 when the final rd equals ZERO_REG.
- Source usage:
  - Rn is read by ADDI, ADDS, SUBS, LDUR, STUR and BR.
  - The second source is Rm for ADDS and SUBS, and the Rd field for STUR and CBZ.
- Load-use hazard: asserted when the EX register holds mem_read=1, ex_rd != ZERO_REG, and ex_rd matches a source the ID instruction actually uses.
  - Effect: stall=1 and the EX register loads a bubble. ID is re-decoded next cycle.
  - A stall lasts exactly 1 cycle per hazard.
- Taken branch (br_taken=1):
  - The EX register loads a bubble, because the ID instruction is the wrong path unless DELAY_SLOT=1.
  - flush_ifid=1 when DELAY_SLOT=0.
  - When DELAY_SLOT=1, flush_ifid=0 and the ID instruction advances normally.
- Simultaneous hazard and br_taken: the branch wins and stall=0. Only flush_cnt increments.
- Pipelining: stage contents advance EX→MEM→WB every cycle. They are never held, because a stall only bubbles EX.
  - An instruction decoded in cycle N is visible on ex_* at N+1, mem_* at N+2 and wb_* at N+3.
- Counters:
  - stall_cnt increments on each cycle with stall=1.
  - flush_cnt increments on each cycle with br_taken=1, in either DELAY_SLOT mode.
  - Both saturate at 2^CNT_W-1 and never wrap.
- rst asserted mid-operation clears all stages and counters at that edge. stall and flush_ifid are 0 in the following cycle.

Test Plan:
- ADDI X1,X2,#4 (opcode 10010001000, rd=1), id_valid=1 → ex_alu_src=1, ex_alu_op=01, ex_sel_se=10000 at N+1; wb_reg_write=1, wb_rd=1 at N+3.
- LDUR X5 followed by ADDS X6,X5,X7 → stall=1 for exactly 1 cycle, one bubble in EX; ADDS reaches WB 1 cycle later than unstalled; stall_cnt=1.
- LDUR X31 followed by a dependent ADDS (rn=31) → no stall; the LDUR's wb_reg_write=0.
- BL with rd=5 → wb_reg_write=1, wb_rd=30, mem_branch=1 at N+2, ex_linked_br=1 at N+1.
- br_taken=1 while a load-use hazard is present → stall=0; flush_ifid=1 with DELAY_SLOT=0 and 0 with DELAY_SLOT=1; flush_cnt=1, stall_cnt unchanged.
- CNT_W=2 with 5 consecutive load-use hazards → stall_cnt stops at 3. Then pulse rst → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/ctrl_pipeline.sv
// ---------------------------------------------------------------------------
// ctrl_pipeline
//   Decodes the ID-stage opcode of the 64-bit ARM pipelined CPU into a control
//   bundle, then carries that bundle through registered EX, MEM and WB stages.
//   It also detects load-use hazards, generates stall/flush controls and keeps
//   saturating stall/flush event counters.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   id_valid          IF/ID holds a real instruction
//   id_opcode         instruction[31:21]
//   id_rn/id_rm/id_rd register fields of the ID instruction
//   br_taken          branch resolved taken in EX this cycle
//   stall             hold PC and IF/ID (one cycle per load-use hazard)
//   flush_ifid        squash IF/ID contents (taken branch, no delay slot)
//   ex_*              EX-stage control outputs
//   mem_*             MEM-stage control outputs
//   wb_*              WB-stage control outputs (incl. destination register)
//   stall_cnt         saturating count of stall cycles
//   flush_cnt         saturating count of taken-branch cycles
//
// There is no FSM and no valid/ready handshake in this block: every stage
// register advances every cycle, and hazards only inject bubbles into EX.
// ---------------------------------------------------------------------------
module ctrl_pipeline #(
  parameter int REG_AW     = 5,
  parameter int ZERO_REG   = 31,
  parameter int LINK_REG   = 30,
  parameter int DELAY_SLOT = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [10:0]       id_opcode,
  input  logic [REG_AW-1:0] id_rn,
  input  logic [REG_AW-1:0] id_rm,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              br_taken,
  output logic              stall,
  output logic              flush_ifid,
  output logic              ex_alu_src,
  output logic [1:0]        ex_alu_op,
  output logic              ex_set_flags,
  output logic [4:0]        ex_sel_se,
  output logic              ex_linked_br,
  output logic              ex_reg_br,
  output logic              mem_branch,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_AW-1:0] wb_rd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [REG_AW-1:0] ZR       = REG_AW'(ZERO_REG);
  localparam logic [REG_AW-1:0] LR       = REG_AW'(LINK_REG);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam bit                KILL_ID  = (DELAY_SLOT == 0);

  // Sign-extend select, one-hot-ish {I, D, B, CB, cbz}; CBZ sets both CB and cbz.
  localparam logic [4:0] SE_I   = 5'b10000;
  localparam logic [4:0] SE_D   = 5'b01000;
  localparam logic [4:0] SE_B   = 5'b00100;
  localparam logic [4:0] SE_CB  = 5'b00010;
  localparam logic [4:0] SE_CBZ = 5'b00011;

  typedef struct packed {
    logic              alu_src;
    logic [1:0]        alu_op;
    logic              set_flags;
    logic [4:0]        sel_se;
    logic              linked_br;
    logic              reg_br;
    logic              branch;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] rd;
  } ex_ctrl_t;

  typedef struct packed {
    logic              branch;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] rd;
  } wb_ctrl_t;

  ex_ctrl_t          w_dec;
  logic              w_known;
  logic              w_use_rn;
  logic              w_use_s2;
  logic [REG_AW-1:0] w_s2;
  logic              w_hazard;
  logic              w_kill_path;

  ex_ctrl_t          r_ex;
  mem_ctrl_t         r_mem;
  wb_ctrl_t          r_wb;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  // ID-stage decode, including which source registers the instruction reads.
  always_comb begin
    w_dec    = '0;
    w_known  = 1'b0;
    w_use_rn = 1'b0;
    w_use_s2 = 1'b0;
    w_s2     = id_rd;
    if (id_valid) begin
      casez (id_opcode)
        11'b1001000100?: begin // ADDI
          w_known = 1'b1; w_use_rn = 1'b1;
          w_dec.alu_src = 1'b1; w_dec.alu_op = 2'b01; w_dec.reg_write = 1'b1;
          w_dec.sel_se = SE_I;
        end
        11'b10101011000: begin // ADDS
          w_known = 1'b1; w_use_rn = 1'b1; w_use_s2 = 1'b1; w_s2 = id_rm;
          w_dec.alu_op = 2'b01; w_dec.reg_write = 1'b1; w_dec.set_flags = 1'b1;
        end
        11'b11101011000: begin // SUBS
          w_known = 1'b1; w_use_rn = 1'b1; w_use_s2 = 1'b1; w_s2 = id_rm;
          w_dec.alu_op = 2'b10; w_dec.reg_write = 1'b1; w_dec.set_flags = 1'b1;
        end
        11'b000101?????: begin // B
          w_known = 1'b1;
          w_dec.branch = 1'b1; w_dec.sel_se = SE_B;
        end
        11'b100101?????: begin // BL
          w_known = 1'b1;
          w_dec.branch = 1'b1; w_dec.sel_se = SE_B; w_dec.linked_br = 1'b1;
          w_dec.reg_write = 1'b1;
        end
        11'b11010110000: begin // BR
          w_known = 1'b1; w_use_rn = 1'b1;
          w_dec.branch = 1'b1; w_dec.sel_se = SE_B; w_dec.reg_br = 1'b1;
        end
        11'b10110100???: begin // CBZ: tests the Rt (Rd field) register
          w_known = 1'b1; w_use_s2 = 1'b1;
          w_dec.branch = 1'b1; w_dec.sel_se = SE_CBZ;
        end
        11'b01010100???: begin // B.LT
          w_known = 1'b1;
          w_dec.alu_src = 1'b1; w_dec.alu_op = 2'b10; w_dec.branch = 1'b1;
          w_dec.sel_se = SE_CB;
        end
        11'b11111000010: begin // LDUR
          w_known = 1'b1; w_use_rn = 1'b1;
          w_dec.alu_src = 1'b1; w_dec.alu_op = 2'b01; w_dec.mem_read = 1'b1;
          w_dec.mem_to_reg = 1'b1; w_dec.reg_write = 1'b1; w_dec.sel_se = SE_D;
        end
        11'b11111000000: begin // STUR: stores the Rt (Rd field) register
          w_known = 1'b1; w_use_rn = 1'b1; w_use_s2 = 1'b1;
          w_dec.alu_src = 1'b1; w_dec.alu_op = 2'b01; w_dec.mem_write = 1'b1;
          w_dec.sel_se = SE_D;
        end
        default: ;
      endcase
    end
    if (w_known) begin
      w_dec.rd = w_dec.linked_br ? LR : id_rd;
    end
    // Writes to the zero register are architecturally discarded.
    if (w_dec.rd == ZR) begin
      w_dec.reg_write = 1'b0;
    end
  end

  // A load in EX whose destination feeds an ID source needs one bubble.
  always_comb begin
    w_hazard = r_ex.mem_read && (r_ex.rd != ZR) &&
               ((w_use_rn && (id_rn == r_ex.rd)) || (w_use_s2 && (w_s2 == r_ex.rd)));
  end

  // A taken branch overrides the hazard: the ID instruction is either on the
  // wrong path (squashed) or a delay-slot instruction (issued as-is).
  assign w_kill_path = br_taken && KILL_ID;
  assign stall       = !rst && w_hazard && !br_taken;
  assign flush_ifid  = !rst && w_kill_path;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_ex <= (w_kill_path || stall) ? '0 : w_dec;

      r_mem.branch     <= r_ex.branch;
      r_mem.mem_read   <= r_ex.mem_read;
      r_mem.mem_write  <= r_ex.mem_write;
      r_mem.reg_write  <= r_ex.reg_write;
      r_mem.mem_to_reg <= r_ex.mem_to_reg;
      r_mem.rd         <= r_ex.rd;

      r_wb.reg_write  <= r_mem.reg_write;
      r_wb.mem_to_reg <= r_mem.mem_to_reg;
      r_wb.rd         <= r_mem.rd;

      if (stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (br_taken && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign ex_alu_src    = r_ex.alu_src;
  assign ex_alu_op     = r_ex.alu_op;
  assign ex_set_flags  = r_ex.set_flags;
  assign ex_sel_se     = r_ex.sel_se;
  assign ex_linked_br  = r_ex.linked_br;
  assign ex_reg_br     = r_ex.reg_br;
  assign mem_branch    = r_mem.branch;
  assign mem_read      = r_mem.mem_read;
  assign mem_write     = r_mem.mem_write;
  assign wb_reg_write  = r_wb.reg_write;
  assign wb_mem_to_reg = r_wb.mem_to_reg;
  assign wb_rd         = r_wb.rd;
  assign stall_cnt     = r_stall_cnt;
  assign flush_cnt     = r_flush_cnt;

endmodule
